// File: rtl/sysid_info_slave.sv
// Avalon-MM system identification slave: ID, timestamp, info word, optional
// 64-bit uptime counter (built when SYSID_UPTIME_EN is defined) and scratch registers.
module sysid_info_slave #(
  parameter logic [31:0] ID_VALUE     = 32'h50BD_7F70,
  parameter logic [31:0] TIMESTAMP    = 32'h0,
  parameter logic [15:0] VERSION      = 16'h0002,
  parameter int          ADDR_W       = 4,
  parameter int          NUM_SCRATCH  = 2,
  parameter logic [31:0] SCRATCH_INIT = 32'h0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam int SCR_BASE = 5;
`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif
  localparam logic [31:0] INFO_WORD = {VERSION, 7'b0, UPTIME_PRESENT, 8'(NUM_SCRATCH)};

  logic [31:0] addr_w;
  logic        wr_en;
  logic [31:0] rd_word;

  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q, rvalid_d;
  logic [NUM_SCRATCH-1:0][31:0] scratch_q, scratch_d;

  // Widen so the scratch upper bound (which may equal 2^ADDR_W) compares cleanly.
  assign addr_w = 32'(address);
  // A simultaneous read wins; the write is dropped.
  assign wr_en  = write & ~read;

`ifdef SYSID_UPTIME_EN
  logic [63:0] uptime_q, uptime_d;
  logic [31:0] shadow_q, shadow_d;

  always_comb begin
    uptime_d = uptime_q + 64'd1;
    if (wr_en && addr_w == 32'd3) uptime_d = '0;
    shadow_d = shadow_q;
    // Snapshot the high half alongside the low-half read for a coherent 64-bit pair.
    if (read && addr_w == 32'd3) shadow_d = uptime_q[63:32];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      uptime_q <= '0;
      shadow_q <= '0;
    end else begin
      uptime_q <= uptime_d;
      shadow_q <= shadow_d;
    end
  end
`endif

  always_comb begin
    scratch_d = scratch_q;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (wr_en && addr_w == 32'(SCR_BASE + i)) scratch_d[i] = writedata;
    end
  end

  always_comb begin
    rd_word = '0;
    case (addr_w)
      32'd0:   rd_word = ID_VALUE;
      32'd1:   rd_word = TIMESTAMP;
      32'd2:   rd_word = INFO_WORD;
`ifdef SYSID_UPTIME_EN
      32'd3:   rd_word = uptime_q[31:0];
      32'd4:   rd_word = shadow_q;
`endif
      default: rd_word = '0;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (addr_w == 32'(SCR_BASE + i)) rd_word = scratch_q[i];
    end
    readdata_d = read ? rd_word : readdata_q;
    rvalid_d   = read;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
      scratch_q  <= {NUM_SCRATCH{SCRATCH_INIT}};
    end else begin
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
      scratch_q  <= scratch_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_info_slave.sv
// Scoreboard bench for sysid_info_slave: driver pushes expected read data,
// a negedge monitor pops and compares whenever readdatavalid is seen.
module tb_sysid_info_slave;

  localparam logic [31:0] ID_VALUE  = 32'h50BD_7F70;
  localparam logic [31:0] TIMESTAMP = 32'h0;
  localparam logic [31:0] SCR_INIT  = 32'h0;
`ifdef SYSID_UPTIME_EN
  localparam logic [31:0] INFO_EXP = 32'h0002_0102;
`else
  localparam logic [31:0] INFO_EXP = 32'h0002_0002;
`endif

  logic        clock;
  logic        reset;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  sysid_info_slave dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] mcnt = '0;
  logic [31:0] exp_shadow = '0;

  // Reference uptime counter: clear beats increment, reset beats everything.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) mcnt <= '0;
    else if (write && !read && address == 4'd3) mcnt <= '0;
    else mcnt <= mcnt + 64'd1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (readdatavalid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected readdatavalid: got data %h with nothing pending", readdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.nm, {32'h0, readdata}, {32'h0, e.data});
        chk({e.nm, " latency"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // All tasks are entered and left on a falling edge.
  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
    read = 1'b1; address = a;
    sb.push_back('{data: exp, cyc: cyc + 1, nm: nm});
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    write = 1'b1; address = a; writedata = d;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic do_rw(input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp, input string nm);
    write = 1'b1; writedata = d;
    do_read(a, exp, nm);
    write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_shadow = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic rd_lo(input string nm);
`ifdef SYSID_UPTIME_EN
    exp_shadow = mcnt[63:32];
    do_read(4'd3, mcnt[31:0], nm);
`else
    do_read(4'd3, 32'h0, nm);
`endif
  endtask

  task automatic rd_hi(input string nm);
`ifdef SYSID_UPTIME_EN
    do_read(4'd4, exp_shadow, nm);
`else
    do_read(4'd4, 32'h0, nm);
`endif
  endtask

  initial begin
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    repeat (3) @(negedge clock);
    chk("reset readdata", {32'h0, readdata}, 64'h0);
    chk("reset readdatavalid", {63'h0, readdatavalid}, 64'h0);
    reset = 1'b0;

    do_read(4'd0, ID_VALUE, "id");
    do_read(4'd1, TIMESTAMP, "timestamp");
    do_read(4'd2, INFO_EXP, "info");

    do_write(4'd5, 32'hDEAD_BEEF);
    do_write(4'd6, 32'h1234_5678);
    do_read(4'd5, 32'hDEAD_BEEF, "scratch0");
    do_read(4'd6, 32'h1234_5678, "scratch1");
    do_read(4'd7, 32'h0, "unmapped7");
    do_read(4'd15, 32'h0, "unmapped15");

    do_write(4'd0, 32'h0);
    do_write(4'd2, 32'hFFFF_FFFF);
    do_read(4'd0, ID_VALUE, "id after write");
    do_read(4'd2, INFO_EXP, "info after write");

    do_rw(4'd5, 32'hAAAA_5555, 32'hDEAD_BEEF, "rw collision");
    do_read(4'd5, 32'hDEAD_BEEF, "scratch0 after rw");

    do_reset();
    rd_hi("stale hi after reset");
    repeat (100) @(negedge clock);
    rd_lo("uptime lo 100");
    rd_hi("uptime hi 100");

`ifdef SYSID_UPTIME_EN
    force dut.uptime_q = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.uptime_q;
    @(negedge clock);
    do_read(4'd3, 32'hFFFF_FFFF, "lo before roll");
    do_read(4'd4, 32'h0, "hi before roll");
    do_read(4'd3, 32'h0000_0001, "lo after roll");
    do_read(4'd4, 32'h0000_0001, "hi after roll");
`endif

    do_write(4'd3, 32'h1234_0000);
`ifdef SYSID_UPTIME_EN
    do_read(4'd3, 32'h0, "lo after clear");
    do_read(4'd3, 32'h1, "lo clear+1");
`else
    do_read(4'd3, 32'h0, "lo absent");
    do_read(4'd4, 32'h0, "hi absent");
`endif
    exp_shadow = '0;
    rd_hi("hi after clear");

    reset = 1'b1;
    do_write(4'd6, 32'h5555_AAAA);
    reset = 1'b0;
    do_read(4'd5, SCR_INIT, "scratch0 after reset");
    do_read(4'd6, SCR_INIT, "scratch1 after reset");

    do_read(4'd0, ID_VALUE, "read before reset");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("readdatavalid after reset", {63'h0, readdatavalid}, 64'h0);
    chk("readdata after reset", {32'h0, readdata}, 64'h0);

    reset = 1'b1; read = 1'b1; address = 4'd1;
    @(negedge clock);
    reset = 1'b0; read = 1'b0;
    chk("readdatavalid read in reset", {63'h0, readdatavalid}, 64'h0);
    chk("readdata read in reset", {32'h0, readdata}, 64'h0);

    repeat (3) @(negedge clock);
    chk("scoreboard drained", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
